mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with its own HI/LO registers.
//  It sits in the EX stage beside the combinational ALU and executes mult, multu, div,
//  divu, mfhi, mflo, mthi and mtlo.
//  The hazard unit stalls on busy|start.
//  It is a parametrised successor to the single-cycle ALU: width is generic, latency
//  is configurable, and it holds internal state.
// PARAMETERS
//  WIDTH        32  operand/HI/LO width in bits (>=2)
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request; sampled on rising clk edge
//  op        in   4      0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO
//  operand1  in   WIDTH  rs value (dividend / multiplicand / MT source)
//  operand2  in   WIDTH  rt value (divisor / multiplier)
//  busy      out  1      a mult/div is in flight
//  hi        out  WIDTH  HI register (architectural)
//  lo        out  WIDTH  LO register (architectural)
//  result    out  WIDTH  comb.: hi if op==MFHI, lo if op==MFLO, else 0
// BEHAVIOUR
//  Reset: busy=0, hi=0, lo=0, counter=0, FSM=IDLE. Takes effect immediately and
//   asynchronously. Reset mid-operation aborts it; hi/lo stay 0.
//  FSM: IDLE -> BUSY on an accepted MULT/MULTU/DIV/DIVU.
//   BUSY -> IDLE when the count expires.
//  Accept: start=1 && busy=0 at edge E0.
//   operand1/operand2/op are latched at E0, so later input changes are ignored.
//  Latency: busy=1 for exactly N cycles after E0 (N=MULT_CYCLES or DIV_CYCLES).
//   At edge E0+N, hi/lo take their new values and busy returns to 0 together.
//   hi/lo hold their old values throughout BUSY.
//  start=1 while busy=1: ignored entirely, with no queueing; op and operands are dropped.
//  MTHI/MTLO with start=1, busy=0: hi (or lo) <= operand1 at that edge; busy stays 0.
//  MFHI/MFLO, NONE or undefined op codes: no state change; result is combinational.
//  The MF read sees the registered hi/lo, not an in-flight value.
//  MULT: signed WIDTHxWIDTH -> 2*WIDTH product; {hi,lo} = product.
//  MULTU: the same, unsigned.
//  DIV: quotient truncates toward zero -> lo; remainder takes the sign of the dividend -> hi.
//  DIVU: unsigned; lo=quotient, hi=remainder.
//  Divide by zero (div and divu): lo = all ones, hi = dividend. Still takes DIV_CYCLES.
//  Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1), hi = 0.
//  Implementation choice is free (shift-add / restoring divider or a pipelined
//   operator), but the busy cycle count must be exact.
//  Completion edge: an accepted start cannot coincide with it, because busy is still 1.
//   The next op may be accepted on the edge after busy falls.
// TESTING
//  1 MULT 0xFFFFFFFD x 7 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  2 DIVU 100/7 -> busy high 10 cycles; then lo=14, hi=2.
//    DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3 DIV 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678.
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4 MULTU 0xFFFFFFFF x 0xFFFFFFFF; drive start=1 with DIV on cycle 2 of busy.
//    -> the DIV is ignored; hi=0xFFFFFFFE, lo=1; busy total 5 cycles.
//  5 MTHI 0xCAFEBABE -> hi updates next edge, busy stays 0.
//    Then op=MFHI -> result=0xCAFEBABE; op=MFLO -> result=lo.
//  6 Start DIV, assert reset asynchronously mid-cycle 4 of busy.
//    -> busy=0, hi=lo=0 immediately; a new MULT 3x4 after release gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
//   start, op, operand1, operand2 : request from the pipeline (master drives)
//   busy, hi, lo, result          : unit status, HI/LO registers and MF read data
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, operand1, operand2,
    input  busy, hi, lo, result
  );

  modport slave (
    input  start, op, operand1, operand2,
    output busy, hi, lo, result
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears FSM, counter, HI and LO
//   bus   : slave side of mult_div_unit_if (start/op/operands in;
//           busy/hi/lo registered out; result combinational MF read)
// Operands are latched on acceptance; the product/quotient is formed from
// the latched copies and written to HI/LO on the final busy edge.
module mult_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_md;
  logic               w_is_mul_req;
  logic               w_accept;
  logic               w_done;
  logic               w_mt_hi;
  logic               w_mt_lo;

  logic [2*WIDTH-1:0] w_prod;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_div_b;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_is_md      = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                        (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign w_is_mul_req = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  // MT writes only when idle; start while busy is dropped.
  assign w_mt_hi      = (r_state == S_IDLE) && bus.start && (bus.op == OP_MTHI);
  assign w_mt_lo      = (r_state == S_IDLE) && bus.start && (bus.op == OP_MTLO);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && w_is_md) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: busy decoded from the state register, MF read is combinational
  always_comb begin
    bus.busy   = (r_state == S_BUSY);
    bus.hi     = r_hi;
    bus.lo     = r_lo;
    bus.result = '0;
    if (bus.op == OP_MFHI)      bus.result = r_hi;
    else if (bus.op == OP_MFLO) bus.result = r_lo;
  end

  // Arithmetic on latched operands; sign/zero extension to 2*WIDTH keeps the
  // low 2*WIDTH product bits correct for both signed and unsigned forms.
  always_comb begin
    if (r_op == OP_MULT)
      w_prod = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    else
      w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  end

  // Signed divide via magnitudes; the -2^(W-1)/-1 case wraps to the
  // required quotient -2^(W-1) with remainder 0 without special handling.
  always_comb begin
    w_neg_a  = (r_op == OP_DIV) && r_a[WIDTH-1];
    w_neg_b  = (r_op == OP_DIV) && r_b[WIDTH-1];
    w_mag_a  = w_neg_a ? -r_a : r_a;
    w_mag_b  = w_neg_b ? -r_b : r_b;
    w_div_b  = (r_b == '0) ? WIDTH'(1) : w_mag_b;
    w_q      = w_mag_a / w_div_b;
    w_r      = w_mag_a % w_div_b;
    if ((r_op == OP_MULT) || (r_op == OP_MULTU)) begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end else if (r_b == '0) begin
      w_res_hi = r_a;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_neg_a ? -w_r : w_r;
      w_res_lo = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
    end
  end

  // Operand latch, cycle counter and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.op;
        r_a   <= bus.operand1;
        r_b   <= bus.operand2;
        // Loaded with N-1 so completion lands exactly N edges after acceptance.
        r_cnt <= w_is_mul_req ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
      end else if (r_state == S_BUSY) begin
        r_cnt <= w_done ? '0 : r_cnt - 1'b1;
      end

      if (w_done) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_mt_hi) begin
        r_hi <= bus.operand1;
      end else if (w_mt_lo) begin
        r_lo <= bus.operand1;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised self-checking bench for mult_div_unit against an arithmetic model.
module tb_mult_div_unit;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(
    .WIDTH(WIDTH), .MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the instruction definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          sq;
    int          sr;
    h = 32'h0;
    l = 32'h0;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {h, l} = sp;
      end
      OP_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        {h, l} = up;
      end
      OP_DIV: begin
        if (b == 32'h0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'h0; l = 32'h8000_0000;
        end else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          h = sr; l = sq;
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          h = a % b; l = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  // Issue a mult/div, optionally attempt a second start on busy cycle 'inject'.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int inject);
    int          n_exp;
    int          cyc;
    logic [31:0] eh;
    logic [31:0] el;
    n_exp = (op == OP_MULT || op == OP_MULTU) ? MULT_CYC : DIV_CYC;
    model(op, a, b, eh, el);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand1 = a; bus.operand2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = OP_NONE; bus.operand1 = $urandom; bus.operand2 = $urandom;
    check_eq("busy_after_accept", 64'(bus.busy), 64'(1));
    check_eq("hi_held", 64'(bus.hi), 64'(m_hi));
    check_eq("lo_held", 64'(bus.lo), 64'(m_lo));
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      if (cyc == inject) begin
        bus.start = 1'b1; bus.op = OP_DIV; bus.operand1 = $urandom; bus.operand2 = $urandom;
      end else begin
        bus.start = 1'b0; bus.op = OP_NONE;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.op = OP_NONE;
    check_eq("busy_cycles", 64'(cyc), 64'(n_exp));
    check_eq("md_hi", 64'(bus.hi), 64'(eh));
    check_eq("md_lo", 64'(bus.lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  // Single-edge request (MT/MF/NONE/undefined): never raises busy.
  task automatic run_misc(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand1 = a; bus.operand2 = $urandom;
    #1;
    if (op == OP_MFHI)      check_eq("mf_result", 64'(bus.result), 64'(m_hi));
    else if (op == OP_MFLO) check_eq("mf_result", 64'(bus.result), 64'(m_lo));
    else                    check_eq("result_zero", 64'(bus.result), 64'(0));
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = OP_NONE;
    if (op == OP_MTHI) m_hi = a;
    if (op == OP_MTLO) m_lo = a;
    check_eq("misc_busy", 64'(bus.busy), 64'(0));
    check_eq("misc_hi", 64'(bus.hi), 64'(m_hi));
    check_eq("misc_lo", 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;
    n_checks = 0;
    n_fail   = 0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_MFHI; bus.operand1 = 32'h0; bus.operand2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'(0));
    check_eq("rst_hi", 64'(bus.hi), 64'(0));
    check_eq("rst_lo", 64'(bus.lo), 64'(0));
    check_eq("rst_result", 64'(bus.result), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    bus.op = OP_NONE;

    // Directed cases
    run_md(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    check_eq("t1_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check_eq("t1_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
    run_md(OP_DIVU, 32'd100, 32'd7, 0);
    check_eq("t2_lo", 64'(bus.lo), 64'd14);
    check_eq("t2_hi", 64'(bus.hi), 64'd2);
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check_eq("t2s_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check_eq("t2s_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    run_md(OP_DIV, 32'h1234_5678, 32'h0, 0);
    check_eq("t3_dz_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
    check_eq("t3_dz_hi", 64'(bus.hi), 64'h0000_0000_1234_5678);
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_eq("t3_ovf_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
    check_eq("t3_ovf_hi", 64'(bus.hi), 64'h0);
    run_md(OP_DIVU, 32'hDEAD_BEEF, 32'h0, 0);
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    check_eq("t4_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check_eq("t4_lo", 64'(bus.lo), 64'd1);
    // Dropped DIV must not start after busy falls
    @(posedge clk); #1;
    check_eq("t4_no_queue", 64'(bus.busy), 64'(0));
    run_misc(OP_MTHI, 32'hCAFE_BABE);
    run_misc(OP_MFHI, 32'h0);
    run_misc(OP_MFLO, 32'h0);
    run_misc(OP_MTLO, 32'h0BAD_F00D);
    run_misc(OP_NONE, 32'h1111_1111);
    run_misc(4'd12, 32'h2222_2222);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.operand1 = 32'd1000; bus.operand2 = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = OP_NONE;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("t6_busy", 64'(bus.busy), 64'(0));
    check_eq("t6_hi", 64'(bus.hi), 64'(0));
    check_eq("t6_lo", 64'(bus.lo), 64'(0));
    m_hi = 32'h0;
    m_lo = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    run_md(OP_MULT, 32'd3, 32'd4, 0);
    check_eq("t6_lo12", 64'(bus.lo), 64'd12);
    check_eq("t6_hi0", 64'(bus.hi), 64'd0);

    // Randomised mix including boundary operand patterns
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rb  = $urandom;
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = 32'($urandom_range(0, 50)) - 32'd25; rb = 32'($urandom_range(0, 10)) - 32'd5; end
      if (rop >= OP_MULT && rop <= OP_DIVU) run_md(rop, ra, rb, (sel == 3) ? 3 : 0);
      else run_misc(rop, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
